worm_squasher_rr: RTL

WORM_SQUASHER_RR -- requirements
Module: worm_squasher_rr

---
 rtl/worm_squasher_rr.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/worm_squasher_rr.sv
// Round-robin shared payload scanner: captures one client's packet, filters inbound
// traffic and compares each payload word against a masked signature table.
module worm_squasher_rr #(
    parameter int          NUM_CLIENTS   = 4,
    parameter int          PAYLOAD_WORDS = 10,
    parameter int          WORD_W        = 56,
    parameter int          NUM_SIGS      = 8,
    parameter logic [31:0] HOME_NET      = 32'h0a010200,
    parameter logic [31:0] HOME_MASK     = 32'hfffffe00,
    localparam int CID_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1,
    localparam int SIG_AW = (NUM_SIGS > 1) ? $clog2(NUM_SIGS) : 1,
    localparam int WIDX_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_CLIENTS-1:0]          req_i,
    input  logic [PAYLOAD_WORDS*WORD_W-1:0] payload_i,
    input  logic [31:0]                     in_ip_i,
    input  logic [31:0]                     out_ip_i,
    input  logic [7:0]                      proto_i,
    input  logic [15:0]                     in_port_i,
    input  logic [15:0]                     out_port_i,
    input  logic                            sig_we_i,
    input  logic [SIG_AW-1:0]               sig_addr_i,
    input  logic [WORD_W-1:0]               sig_data_i,
    input  logic [WORD_W-1:0]               sig_mask_i,
    input  logic                            sig_en_i,
    output logic [NUM_CLIENTS-1:0]          grant_o,
    output logic [CID_W-1:0]                clientid_o,
    output logic                            busy_o,
    output logic                            valid_o,
    output logic                            match_o,
    output logic [SIG_AW-1:0]               sig_idx_o,
    output logic [WIDX_W-1:0]               word_idx_o,
    output logic [15:0]                     match_count_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                      state_q, state_d;
    logic [WIDX_W-1:0]               widx_q, widx_d;
    logic [CID_W-1:0]                rr_ptr_q;
    logic [NUM_CLIENTS-1:0]          grant_q;
    logic [CID_W-1:0]                clientid_q;
    logic                            match_q;
    logic [SIG_AW-1:0]               sig_idx_q;
    logic [WIDX_W-1:0]               word_idx_q;
    logic [15:0]                     count_q;
    logic [PAYLOAD_WORDS*WORD_W-1:0] payload_q;
    logic [31:0]                     in_ip_q, out_ip_q;
    logic [7:0]                      proto_q;
    logic [15:0]                     in_port_q, out_port_q;

    logic [WORD_W-1:0]               sig_data_q [NUM_SIGS];
    logic [WORD_W-1:0]               sig_mask_q [NUM_SIGS];
    logic [NUM_SIGS-1:0]             sig_en_q;

    logic                            win_found;
    logic [CID_W-1:0]                win_id;
    logic                            inbound;
    logic [WORD_W-1:0]               cur_word;
    logic                            hit_any;
    logic [SIG_AW-1:0]               hit_idx;
    logic                            scan_hit;
    logic                            last_word;
    logic                            unused_hdr;

    // Round-robin search starts one past the last winner and wraps.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 1; i <= NUM_CLIENTS; i++) begin
            if (!win_found && req_i[CID_W'((int'(rr_ptr_q) + i) % NUM_CLIENTS)]) begin
                win_found = 1'b1;
                win_id    = CID_W'((int'(rr_ptr_q) + i) % NUM_CLIENTS);
            end
        end
    end

    assign inbound   = ((in_ip_q & HOME_MASK) != HOME_NET) && ((out_ip_q & HOME_MASK) == HOME_NET);
    assign cur_word  = payload_q[int'(widx_q)*WORD_W +: WORD_W];
    assign last_word = (widx_q == WIDX_W'(PAYLOAD_WORDS - 1));
    assign scan_hit  = inbound && hit_any;

    // Descending walk so the lowest hitting entry is the one left in hit_idx.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int s = NUM_SIGS - 1; s >= 0; s--) begin
            if (sig_en_q[s] && ((cur_word & sig_mask_q[s]) == (sig_data_q[s] & sig_mask_q[s]))) begin
                hit_any = 1'b1;
                hit_idx = SIG_AW'(s);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_SCAN;
                    widx_d  = '0;
                end
            end
            ST_SCAN: begin
                if (!inbound || hit_any || last_word) begin
                    state_d = ST_DONE;
                end else begin
                    widx_d = widx_q + WIDX_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SIGS; s++) begin
                sig_data_q[s] <= '0;
                sig_mask_q[s] <= '0;
            end
            sig_en_q <= '0;
        end else if (sig_we_i && (int'(sig_addr_i) < NUM_SIGS)) begin
            sig_data_q[sig_addr_i] <= sig_data_i;
            sig_mask_q[sig_addr_i] <= sig_mask_i;
            sig_en_q[sig_addr_i]   <= sig_en_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            widx_q     <= '0;
            rr_ptr_q   <= CID_W'(NUM_CLIENTS - 1);
            grant_q    <= '0;
            clientid_q <= '0;
            match_q    <= 1'b0;
            sig_idx_q  <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            payload_q  <= '0;
            in_ip_q    <= '0;
            out_ip_q   <= '0;
            proto_q    <= '0;
            in_port_q  <= '0;
            out_port_q <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            grant_q <= '0;
            if (state_q == ST_IDLE && win_found) begin
                grant_q    <= NUM_CLIENTS'(1) << win_id;
                clientid_q <= win_id;
                rr_ptr_q   <= win_id;
                payload_q  <= payload_i;
                in_ip_q    <= in_ip_i;
                out_ip_q   <= out_ip_i;
                proto_q    <= proto_i;
                in_port_q  <= in_port_i;
                out_port_q <= out_port_i;
            end
            // Result registers and the counter move together on entry to DONE.
            if (state_q == ST_SCAN && state_d == ST_DONE) begin
                match_q    <= scan_hit;
                sig_idx_q  <= scan_hit ? hit_idx : '0;
                word_idx_q <= scan_hit ? widx_q : '0;
                if (scan_hit && count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
            end
        end
    end

    assign unused_hdr = ^{proto_q, in_port_q, out_port_q};

    assign grant_o       = grant_q;
    assign clientid_o    = clientid_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign valid_o       = (state_q == ST_DONE);
    assign match_o       = match_q;
    assign sig_idx_o     = sig_idx_q;
    assign word_idx_o    = word_idx_q;
    assign match_count_o = count_q;

endmodule
